data_mem_responder: RTL and testbench

- Responder end of the processor's data-memory port: accepts read/write requests from the MEM stage, serves them after a fixed number of wait states, and returns data with a ready handshake.
- Performs byte/half/word lane selection and load sign/zero extension according to func3.
- Owns the word-organised data RAM. Sits between the pipelined core and the memory array; the core's hazard unit stalls on ready low.

---
 rtl/data_mem_responder_pkg.sv | 34 +++
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/dmem_lane_align.sv | 70 +++++++
 rtl/data_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: access-type codes,
// responder FSM states and small access-classification helpers.
package data_mem_responder_pkg;

  // Load access types. Store codes reuse the low three values.
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } mem_func3_t;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } dmem_state_t;

  // Store codes are only byte, half and word.
  function automatic logic isLegalStore(input logic [2:0] f3);
    return (f3 == SB) || (f3 == SH) || (f3 == SW);
  endfunction

  // Loads additionally allow the unsigned byte/half forms.
  function automatic logic isLegalLoad(input logic [2:0] f3);
    return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the
// data-memory responder (slave).
interface data_mem_responder_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int FUNC3_WIDTH = 3
);
  logic                   memRead;
  logic                   memWrite;
  logic [FUNC3_WIDTH-1:0] func3;
  logic [DATA_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  wData;
  logic [DATA_WIDTH-1:0]  rData;
  logic                   ready;
  logic                   accessFault;

  modport master (
    output memRead, memWrite, func3, addr, wData,
    input  rData, ready, accessFault
  );

  modport slave (
    input  memRead, memWrite, func3, addr, wData,
    output rData, ready, accessFault
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: builds store byte enables and the
// replicated store word, extracts and extends load values, and flags
// misaligned or illegal access types. Lanes assume a 32-bit word.
module dmem_lane_align
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FUNC3_WIDTH = 3
) (
  input  logic [FUNC3_WIDTH-1:0] func3,
  input  logic                   isStore,
  input  logic [1:0]             byteOff,
  input  logic [DATA_WIDTH-1:0]  wData,
  input  logic [DATA_WIDTH-1:0]  rawWord,
  output logic [3:0]             byteEn,
  output logic [DATA_WIDTH-1:0]  storeWord,
  output logic [DATA_WIDTH-1:0]  loadValue,
  output logic                   fault
);

  logic [2:0]  f3;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  assign f3       = func3[2:0];
  assign laneByte = rawWord[{byteOff, 3'b000} +: 8];
  assign laneHalf = byteOff[1] ? rawWord[31:16] : rawWord[15:0];

  // Decode the access into lane enables / extended data and a fault flag.
  always_comb begin
    byteEn    = 4'b0000;
    storeWord = wData;
    loadValue = '0;
    fault     = 1'b0;
    if (isStore) begin
      if (!isLegalStore(f3)) begin
        fault = 1'b1;
      end else if (f3 == SB) begin
        byteEn    = 4'b0001 << byteOff;
        storeWord = {4{wData[7:0]}};
      end else if (f3 == SH) begin
        storeWord = {2{wData[15:0]}};
        if (byteOff[0]) fault = 1'b1;
        else            byteEn = byteOff[1] ? 4'b1100 : 4'b0011;
      end else begin
        if (byteOff != 2'b00) fault = 1'b1;
        else                  byteEn = 4'b1111;
      end
    end else begin
      case (f3)
        LB:  loadValue = {{(DATA_WIDTH-8){laneByte[7]}}, laneByte};
        LBU: loadValue = {{(DATA_WIDTH-8){1'b0}}, laneByte};
        LH: begin
          if (byteOff[0]) fault = 1'b1;
          else            loadValue = {{(DATA_WIDTH-16){laneHalf[15]}}, laneHalf};
        end
        LHU: begin
          if (byteOff[0]) fault = 1'b1;
          else            loadValue = {{(DATA_WIDTH-16){1'b0}}, laneHalf};
        end
        LW: begin
          if (byteOff != 2'b00) fault = 1'b1;
          else                  loadValue = rawWord;
        end
        default: fault = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts a load/store from the MEM stage, completes
// it after WAIT_STATES extra cycles and signals completion on ready. Owns the
// word-organised data RAM (contents are not reset).
// Optional feature macro: DMEM_PERF_CNT_EN enables the rd/wr/stall counters;
// without it the counter outputs are tied to zero.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DM_MEM_DEPTH = 4096,
  parameter int DATA_WIDTH   = 32,
  parameter int FUNC3_WIDTH  = 3,
  parameter int WAIT_STATES  = 2
) (
  input  logic                 clk,
  input  logic                 rstN,
  data_mem_responder_if.slave  bus,
  output logic [31:0]          rdCount,
  output logic [31:0]          wrCount,
  output logic [31:0]          stallCount
);

  localparam int IDX_W = $clog2(DM_MEM_DEPTH);
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
  localparam bit ZERO_WAIT = (WAIT_STATES == 0);

  dmem_state_t            state;
  logic [CNT_W-1:0]       waitCnt;
  logic [FUNC3_WIDTH-1:0] func3Q;
  logic [IDX_W+1:0]       addrQ;
  logic [DATA_WIDTH-1:0]  wDataQ;
  logic                   isStoreQ;
  logic                   bothQ;
  logic [DATA_WIDTH-1:0]  rDataQ;
  logic                   accessFaultQ;

  logic                   req;
  logic                   inIdle;
  logic                   enterDone;
  logic                   ready;
  logic [FUNC3_WIDTH-1:0] accFunc3;
  logic [IDX_W+1:0]       accAddr;
  logic [DATA_WIDTH-1:0]  accWData;
  logic                   accStore;
  logic                   accBoth;
  logic                   accFault;
  logic                   alignFault;
  logic                   commit;
  logic [IDX_W-1:0]       wordIdx;
  logic [DATA_WIDTH-1:0]  rawWord;
  logic [3:0]             byteEn;
  logic [DATA_WIDTH-1:0]  storeWord;
  logic [DATA_WIDTH-1:0]  loadValue;

  logic [DATA_WIDTH-1:0]  mem [DM_MEM_DEPTH];

  assign req    = bus.memRead | bus.memWrite;
  assign inIdle = (state == IDLE);

  // With zero wait states the access completes straight out of IDLE, so the
  // live bus values stand in for the not-yet-latched copies.
  assign accFunc3 = inIdle ? bus.func3 : func3Q;
  assign accAddr  = inIdle ? bus.addr[IDX_W+1:0] : addrQ;
  assign accWData = inIdle ? bus.wData : wDataQ;
  assign accStore = inIdle ? (bus.memWrite & ~bus.memRead) : isStoreQ;
  assign accBoth  = inIdle ? (bus.memWrite & bus.memRead) : bothQ;

  assign enterDone = (inIdle && req && ZERO_WAIT) ||
                     ((state == WAIT) && (waitCnt == LAST_CNT));

  assign wordIdx = accAddr[IDX_W+1:2];
  assign rawWord = mem[wordIdx];

  dmem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .FUNC3_WIDTH(FUNC3_WIDTH)
  ) laneAlign (
    .func3    (accFunc3),
    .isStore  (accStore),
    .byteOff  (accAddr[1:0]),
    .wData    (accWData),
    .rawWord  (rawWord),
    .byteEn   (byteEn),
    .storeWord(storeWord),
    .loadValue(loadValue),
    .fault    (alignFault)
  );

  assign accFault = alignFault | accBoth;
  assign commit   = enterDone & accStore & ~accFault;

  assign ready           = (inIdle & ~req) | (state == DONE);
  assign bus.ready       = ready;
  assign bus.rData       = rDataQ;
  assign bus.accessFault = accessFaultQ;

  // Responder FSM: latch the request, count wait states, register load data
  // and the fault flag on the edge entering DONE.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state        <= IDLE;
      waitCnt      <= '0;
      func3Q       <= '0;
      addrQ        <= '0;
      wDataQ       <= '0;
      isStoreQ     <= 1'b0;
      bothQ        <= 1'b0;
      rDataQ       <= '0;
      accessFaultQ <= 1'b0;
    end else begin
      accessFaultQ <= enterDone & accFault;
      if (enterDone && (!accStore || accFault)) begin
        rDataQ <= accFault ? '0 : loadValue;
      end
      case (state)
        IDLE: begin
          if (req) begin
            func3Q   <= bus.func3;
            addrQ    <= bus.addr[IDX_W+1:0];
            wDataQ   <= bus.wData;
            isStoreQ <= bus.memWrite & ~bus.memRead;
            bothQ    <= bus.memWrite & bus.memRead;
            waitCnt  <= '0;
            state    <= ZERO_WAIT ? DONE : WAIT;
          end
        end
        WAIT: begin
          waitCnt <= waitCnt + CNT_W'(1);
          if (waitCnt == LAST_CNT) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Byte-enabled store commit into the array on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[wordIdx][8*b +: 8] <= storeWord[8*b +: 8];
      end
    end
  end

`ifdef DMEM_PERF_CNT_EN
  // Performance counters: completed loads/stores and cycles with ready low.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rdCount    <= '0;
      wrCount    <= '0;
      stallCount <= '0;
    end else begin
      if (enterDone && !accStore) rdCount <= rdCount + 32'd1;
      if (enterDone && accStore)  wrCount <= wrCount + 32'd1;
      if (!ready)                 stallCount <= stallCount + 32'd1;
    end
  end
`else
  assign rdCount    = '0;
  assign wrCount    = '0;
  assign stallCount = '0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: table of load/store vectors checked through
// an expected-result queue, plus hand-written reset, hold-over and zero-wait
// sequences.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int WS = 2;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wData;
    logic [31:0] expData;
    logic        expFault;
  } vec_t;

  typedef struct {
    logic        isLoad;
    logic [31:0] data;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic [31:0] rdCount, wrCount, stallCount;
  logic [31:0] rdCountZ, wrCountZ, stallCountZ;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  vec_t vecs[$];

  data_mem_responder_if bus();
  data_mem_responder_if busZ();

  always #5 clk = ~clk;

  data_mem_responder #(.WAIT_STATES(WS)) dut (
    .clk(clk), .rstN(rstN), .bus(bus),
    .rdCount(rdCount), .wrCount(wrCount), .stallCount(stallCount)
  );

  data_mem_responder #(.WAIT_STATES(0)) dutZ (
    .clk(clk), .rstN(rstN), .bus(busZ),
    .rdCount(rdCountZ), .wrCount(wrCountZ), .stallCount(stallCountZ)
  );

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] expData, input logic expFault);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wData = wd;
    v.expData = expData; v.expFault = expFault;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timeout waiting for ready", name);
  endtask

  // Drive one access on the WS=2 responder, hold it until ready, then check.
  task automatic applyStimulus(input vec_t v, input string name);
    exp_t e;
    int stall;
    bit seen;
    @(posedge clk); #1;
    bus.memRead = v.rd; bus.memWrite = v.wr; bus.func3 = v.f3;
    bus.addr = v.addr; bus.wData = v.wData;
    e.isLoad = v.rd; e.data = v.expData; e.fault = v.expFault;
    sb.push_back(e);
    stall = 0; seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.ready) seen = 1; else stall++;
    end
    e = sb.pop_front();
    if (!seen) begin
      timeoutFail(name);
    end else begin
      checkOutput({name, " stall"}, 32'(stall), 32'(1 + WS));
      checkOutput({name, " fault"}, {31'd0, bus.accessFault}, {31'd0, e.fault});
      if (e.isLoad || e.fault) checkOutput({name, " rData"}, bus.rData, e.data);
    end
    @(posedge clk); #1;
    bus.memRead = 1'b0; bus.memWrite = 1'b0;
  endtask

  // Same access sequence on the zero-wait responder.
  task automatic accessZ(input logic rd, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] expData, input string name);
    int stall;
    bit seen;
    @(posedge clk); #1;
    busZ.memRead = rd; busZ.memWrite = ~rd; busZ.func3 = f3;
    busZ.addr = addr; busZ.wData = wd;
    stall = 0; seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (busZ.ready) seen = 1; else stall++;
    end
    if (!seen) begin
      timeoutFail(name);
    end else begin
      checkOutput({name, " stall"}, 32'(stall), 32'd1);
      if (rd) checkOutput({name, " rData"}, busZ.rData, expData);
    end
    @(posedge clk); #1;
    busZ.memRead = 1'b0; busZ.memWrite = 1'b0;
  endtask

  initial begin
    int c;
    bit seen;
    logic [31:0] r0, w0, s0;

    vecs.push_back(mk(0, 1, SW,  32'h10,   32'hDEADBEEF, 32'h0,        0));
    vecs.push_back(mk(1, 0, LW,  32'h10,   32'h0,        32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 0, LB,  32'h13,   32'h0,        32'hFFFFFFDE, 0));
    vecs.push_back(mk(1, 0, LBU, 32'h13,   32'h0,        32'h000000DE, 0));
    vecs.push_back(mk(1, 0, LH,  32'h12,   32'h0,        32'hFFFFDEAD, 0));
    vecs.push_back(mk(1, 0, LHU, 32'h10,   32'h0,        32'h0000BEEF, 0));
    vecs.push_back(mk(0, 1, SB,  32'h11,   32'hAAAAAA55, 32'h0,        0));
    vecs.push_back(mk(1, 0, LW,  32'h10,   32'h0,        32'hDEAD55EF, 0));
    vecs.push_back(mk(0, 1, SH,  32'h12,   32'hFFFF1234, 32'h0,        0));
    vecs.push_back(mk(1, 0, LW,  32'h10,   32'h0,        32'h123455EF, 0));
    vecs.push_back(mk(1, 0, LB,  32'h11,   32'h0,        32'h00000055, 0));
    vecs.push_back(mk(1, 0, LW,  32'h12,   32'h0,        32'h0,        1));
    vecs.push_back(mk(0, 1, SW,  32'h11,   32'h0,        32'h0,        1));
    vecs.push_back(mk(1, 0, LW,  32'h10,   32'h0,        32'h123455EF, 0));
    vecs.push_back(mk(1, 0, LW,  32'h4010, 32'h0,        32'h123455EF, 0));
    vecs.push_back(mk(0, 1, SW,  32'h20,   32'h80007F01, 32'h0,        0));
    vecs.push_back(mk(1, 0, LH,  32'h22,   32'h0,        32'hFFFF8000, 0));
    vecs.push_back(mk(1, 0, LHU, 32'h22,   32'h0,        32'h00008000, 0));
    vecs.push_back(mk(1, 0, LH,  32'h20,   32'h0,        32'h00007F01, 0));
    vecs.push_back(mk(1, 0, LB,  32'h21,   32'h0,        32'h0000007F, 0));
    vecs.push_back(mk(1, 0, LBU, 32'h20,   32'h0,        32'h00000001, 0));
    vecs.push_back(mk(1, 0, 3'b011, 32'h20, 32'h0,       32'h0,        1));
    vecs.push_back(mk(1, 0, 3'b110, 32'h20, 32'h0,       32'h0,        1));
    vecs.push_back(mk(0, 1, 3'b100, 32'h20, 32'hFFFFFFFF, 32'h0,       1));
    vecs.push_back(mk(1, 0, LH,  32'h21,   32'h0,        32'h0,        1));
    vecs.push_back(mk(1, 0, LHU, 32'h13,   32'h0,        32'h0,        1));
    vecs.push_back(mk(0, 1, SH,  32'h23,   32'hFFFFFFFF, 32'h0,        1));
    vecs.push_back(mk(1, 1, LW,  32'h20,   32'h0,        32'h0,        1));
    vecs.push_back(mk(1, 0, LW,  32'h20,   32'h0,        32'h80007F01, 0));

    bus.memRead = 0; bus.memWrite = 0; bus.func3 = 0; bus.addr = 0; bus.wData = 0;
    busZ.memRead = 0; busZ.memWrite = 0; busZ.func3 = 0; busZ.addr = 0; busZ.wData = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("reset ready", {31'd0, bus.ready}, 32'd1);
    checkOutput("reset rData", bus.rData, 32'd0);
    checkOutput("reset fault", {31'd0, bus.accessFault}, 32'd0);
    checkOutput("reset readyZ", {31'd0, busZ.ready}, 32'd1);
`ifdef DMEM_PERF_CNT_EN
    checkOutput("reset rdCount", rdCount, 32'd0);
    checkOutput("reset stallCount", stallCount, 32'd0);
`endif

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Request held past DONE is a fresh access; dropping it mid-WAIT still completes.
    @(posedge clk); #1;
    bus.memRead = 1; bus.func3 = LW; bus.addr = 32'h10;
    seen = 0;
    for (c = 0; c < 20 && !seen; c++) begin @(negedge clk); if (bus.ready) seen = 1; end
    if (!seen) timeoutFail("hold first");
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("hold reissue ready", {31'd0, bus.ready}, 32'd0);
    @(posedge clk); #1;
    bus.memRead = 0; bus.addr = 32'h20;
    @(negedge clk);
    checkOutput("drop in WAIT ready", {31'd0, bus.ready}, 32'd0);
    seen = 0;
    for (c = 0; c < 20 && !seen; c++) begin @(negedge clk); if (bus.ready) seen = 1; end
    if (!seen) timeoutFail("drop in WAIT");
    checkOutput("drop in WAIT rData", bus.rData, 32'h123455EF);
    checkOutput("drop in WAIT fault", {31'd0, bus.accessFault}, 32'd0);

    // Reset during a store's WAIT aborts it without a commit.
    applyStimulus(mk(0, 1, SW, 32'h30, 32'hCAFEF00D, 32'h0, 0), "base SW");
    applyStimulus(mk(1, 0, LW, 32'h30, 32'h0, 32'hCAFEF00D, 0), "base LW");
    @(posedge clk); #1;
    bus.memWrite = 1; bus.func3 = SW; bus.addr = 32'h30; bus.wData = 32'h11111111;
    @(posedge clk); #1;
    rstN = 1'b0;
    bus.memWrite = 0;
    @(negedge clk);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("post-reset ready", {31'd0, bus.ready}, 32'd1);
    checkOutput("post-reset rData", bus.rData, 32'd0);
    checkOutput("post-reset fault", {31'd0, bus.accessFault}, 32'd0);
`ifdef DMEM_PERF_CNT_EN
    checkOutput("post-reset wrCount", wrCount, 32'd0);
`endif
    applyStimulus(mk(1, 0, LW, 32'h30, 32'h0, 32'hCAFEF00D, 0), "aborted SW");

    // Counter deltas over two loads and one store.
    r0 = rdCount; w0 = wrCount; s0 = stallCount;
    applyStimulus(mk(1, 0, LW, 32'h10, 32'h0, 32'h123455EF, 0), "perf LW0");
    applyStimulus(mk(1, 0, LBU, 32'h33, 32'h0, 32'h000000CA, 0), "perf LBU");
    applyStimulus(mk(0, 1, SW, 32'h40, 32'h01020304, 32'h0, 0), "perf SW");
`ifdef DMEM_PERF_CNT_EN
    checkOutput("perf rdCount", rdCount - r0, 32'd2);
    checkOutput("perf wrCount", wrCount - w0, 32'd1);
    checkOutput("perf stallCount", stallCount - s0, 32'd9);
`else
    checkOutput("tied rdCount", rdCount, 32'd0);
    checkOutput("tied stallCount", stallCount, 32'd0);
`endif

    // Zero wait states: single stall cycle per access.
    s0 = stallCountZ;
    accessZ(0, SW, 32'h40, 32'h89ABCDEF, 32'h0, "zero SW");
    accessZ(1, LH, 32'h42, 32'h0, 32'hFFFF89AB, "zero LH");
`ifdef DMEM_PERF_CNT_EN
    checkOutput("zero stallCount", stallCountZ - s0, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
